// File: rtl/reg_file_sb.sv
// reg_file_sb -- register file with forwarding and a busy scoreboard.
//
// After reset, a clear sequencer zeroes one entry per cycle. The file
// reports ready only once every entry has been cleared.
//
// Ports:
//   clk, rst           rising-edge clock; synchronous active-high reset
//   ready              high once the clear sequence has finished
//   r_addr1/2          read addresses
//   r_rs1/2            combinational read data, with write forwarding
//   rs1_busy/rs2_busy  scoreboard bit for r_addr1 / r_addr2
//   w_en/w_addr/w_data write port; a write clears busy[w_addr]
//   rsv_en/rsv_addr    reserve port; sets busy[rsv_addr]
//
// state  | meaning
// -------+--------------------------------------------------------
// CLEAR  | zeroing rfile[cnt] each cycle; outputs gated; writes ignored
// RUN    | normal operation; ready = 1
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   r_addr1,
    input  logic [AW-1:0]   r_addr2,
    output logic [XLEN-1:0] r_rs1,
    output logic [XLEN-1:0] r_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            w_en,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr
);

    typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  rfile_q [NREGS];
    logic [XLEN-1:0]  rfile_d [NREGS];

    // True for the hard-wired zero register when that option is enabled.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // State register and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // The array has no reset. The clear sequence is what zeroes it.
    always_ff @(posedge clk) begin
        rfile_q <= rfile_d;
    end

    // Next state and clear counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Array and scoreboard updates. The reserve is applied after the
    // write, so a same-address reserve wins and leaves busy set.
    always_comb begin
        rfile_d = rfile_q;
        busy_d  = busy_q;
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                rfile_d[cnt_q] = '0;
            end else begin
                if (w_en && !is_zero(w_addr)) begin
                    rfile_d[w_addr] = w_data;
                    busy_d[w_addr]  = 1'b0;
                end
                if (rsv_en && !is_zero(rsv_addr)) begin
                    busy_d[rsv_addr] = 1'b1;
                end
            end
        end
    end

    // Outputs: gated to zero in CLEAR; in RUN, an in-flight write is forwarded.
    always_comb begin
        ready    = 1'b0;
        r_rs1    = '0;
        r_rs2    = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (state_q == S_RUN) begin
            ready = 1'b1;
            if (is_zero(r_addr1)) begin
                r_rs1 = '0;
            end else if (w_en && (w_addr == r_addr1)) begin
                r_rs1 = w_data;
            end else begin
                r_rs1    = rfile_q[r_addr1];
                rs1_busy = busy_q[r_addr1];
            end
            if (is_zero(r_addr2)) begin
                r_rs2 = '0;
            end else if (w_en && (w_addr == r_addr2)) begin
                r_rs2 = w_data;
            end else begin
                r_rs2    = rfile_q[r_addr2];
                rs2_busy = busy_q[r_addr2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb. It drives two instances from one stimulus stream:
//   inst a: XLEN=32, NREGS=32, ZERO_REG=1
//   inst b: XLEN=64, NREGS=8,  ZERO_REG=0
// The driver pushes the reference model's expected outputs for each cycle.
// A monitor pops and compares them on the falling edge.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en, rsv_en;
    logic [4:0]  w_addr, rsv_addr, ra1, ra2;
    logic [63:0] w_data;

    logic        a_ready, a_b1, a_b2;
    logic [31:0] a_rs1, a_rs2;
    logic        b_ready, b_b1, b_b2;
    logic [63:0] b_rs1, b_rs2;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .ready(a_ready),
        .r_addr1(ra1), .r_addr2(ra2),
        .r_rs1(a_rs1), .r_rs2(a_rs2), .rs1_busy(a_b1), .rs2_busy(a_b2),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data[31:0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    reg_file_sb #(.XLEN(64), .NREGS(8), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .ready(b_ready),
        .r_addr1(ra1[2:0]), .r_addr2(ra2[2:0]),
        .r_rs1(b_rs1), .r_rs2(b_rs2), .rs1_busy(b_b1), .rs2_busy(b_b2),
        .w_en(w_en), .w_addr(w_addr[2:0]), .w_data(w_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr[2:0])
    );

    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        b1;
        logic        b2;
        logic        rdy;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the contents and pending-writer set of each file,
    // plus how many clear cycles are still outstanding.
    int          NR[2]   = '{32, 8};
    bit          ZR[2]   = '{1'b1, 1'b0};
    logic [63:0] MASK[2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] m_rf[2][32];
    bit          m_busy[2][32];
    int          m_clr[2];
    bit          m_known = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_read(input int i, input logic [4:0] a_raw, input bit we,
                              input logic [4:0] wa_raw, input logic [63:0] wd,
                              output logic [63:0] d, output logic b);
        int a, w;
        a = int'(a_raw) % NR[i];
        w = int'(wa_raw) % NR[i];
        d = '0;
        b = 1'b0;
        if (m_clr[i] != 0) begin
            d = '0;
        end else if (ZR[i] && a == 0) begin
            d = '0;
        end else if (we && w == a) begin
            d = wd & MASK[i];
        end else begin
            d = m_rf[i][a];
            b = m_busy[i][a];
        end
    endtask

    task automatic model_update(input int i, input bit r, input bit we,
                                input logic [4:0] wa_raw, input logic [63:0] wd,
                                input bit re, input logic [4:0] ra_raw);
        int w, v;
        w = int'(wa_raw) % NR[i];
        v = int'(ra_raw) % NR[i];
        if (r) begin
            m_clr[i] = NR[i];
            for (int k = 0; k < 32; k++) begin
                m_rf[i][k]   = '0;
                m_busy[i][k] = 1'b0;
            end
        end else if (m_clr[i] > 0) begin
            m_clr[i]--;
        end else begin
            if (we && !(ZR[i] && w == 0)) begin
                m_rf[i][w]   = wd & MASK[i];
                m_busy[i][w] = 1'b0;
            end
            if (re && !(ZR[i] && v == 0)) m_busy[i][v] = 1'b1;
        end
    endtask

    // Drives one cycle, records what both instances should show before the
    // edge, advances the model across the edge, then waits for that edge.
    task automatic drive(input bit r, input bit we, input logic [4:0] wa,
                         input logic [63:0] wd, input bit re, input logic [4:0] rv,
                         input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rst = r; w_en = we; w_addr = wa; w_data = wd;
        rsv_en = re; rsv_addr = rv; ra1 = a1; ra2 = a2;
        for (int i = 0; i < 2; i++) begin
            if (m_known) begin
                e.rdy = (m_clr[i] == 0);
                model_read(i, a1, we, wa, wd, e.rs1, e.b1);
                model_read(i, a2, we, wa, wd, e.rs2, e.b2);
                if (i == 0) qa.push_back(e);
                else qb.push_back(e);
            end
            model_update(i, r, we, wa, wd, re, rv);
        end
        if (r) m_known = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, a1, a2);
    endtask

    // Monitor.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_ready", {63'd0, a_ready}, {63'd0, e.rdy});
            chk("a_rs1", {32'd0, a_rs1}, e.rs1);
            chk("a_rs2", {32'd0, a_rs2}, e.rs2);
            chk("a_rs1_busy", {63'd0, a_b1}, {63'd0, e.b1});
            chk("a_rs2_busy", {63'd0, a_b2}, {63'd0, e.b2});
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_ready", {63'd0, b_ready}, {63'd0, e.rdy});
            chk("b_rs1", b_rs1, e.rs1);
            chk("b_rs2", b_rs2, e.rs2);
            chk("b_rs1_busy", {63'd0, b_b1}, {63'd0, e.b1});
            chk("b_rs2_busy", {63'd0, b_b2}, {63'd0, e.b2});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  wa, a1, a2;
        logic [63:0] wd;
        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; ra1 = '0; ra2 = '0;

        // Reset, then the clear sequence, then read every address.
        drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 34; k++) idle(5'(k), 5'(31 - k));
        for (int k = 0; k < 32; k++) idle(5'(k), 5'(31 - k));

        // Basic write/read and the zero register.
        drive(1'b0, 1'b1, 5'd5, 64'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd13);
        drive(1'b0, 1'b1, 5'd0, 64'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Same-cycle forwarding.
        drive(1'b0, 1'b1, 5'd7, 64'hA5A5A5A5_A5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Scoreboard: reserve, write, then write and reserve together.
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd11);
        idle(5'd3, 5'd11);
        drive(1'b0, 1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);
        drive(1'b0, 1'b1, 5'd3, 64'h99, 1'b1, 5'd3, 5'd3, 5'd4);
        idle(5'd3, 5'd11);

        // x0 on the ZERO_REG=0 instance: all-ones write and reserve.
        drive(1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd8);
        drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd8);
        idle(5'd0, 5'd8);

        // Mid-run reset; write pulses during the clear must be ignored.
        drive(1'b0, 1'b1, 5'd9, 64'h77, 1'b1, 5'd10, 5'd9, 5'd10);
        drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd10);
        for (int k = 0; k < 33; k++)
            drive(1'b0, k[0], 5'd9, 64'hBAD0 + 64'(k), k[1], 5'd9, 5'd9, 5'd10);
        idle(5'd9, 5'd10);

        // Randomised traffic, with an occasional reset.
        for (int n = 0; n < 1500; n++) begin
            wa = 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, wa, wd,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), a1, a2);
        end

        @(negedge clk);
        #1;
        chk("queue_drain_a", 64'(qa.size()), 64'd0);
        chk("queue_drain_b", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the OtterMCU pipeline. It provides two combinational read ports, one write port and write-to-read forwarding. A per-register busy scoreboard lets the decode stage detect RAW hazards. A reset-driven clear sequencer zeroes every entry, one per cycle, so the array needs no `initial` block and behaves the same in simulation and on hardware. It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers; power of two, ≥ 2
- ZERO_REG, 1, if 1, register 0 reads 0 forever, ignores writes and reservations, and is never busy
- AW, $clog2(NREGS), address width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; synchronous and active-high
- ready  out  1  high when the clear sequence is done and the file is usable
- r_addr1, r_addr2  in  AW  read addresses
- r_rs1, r_rs2  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  scoreboard bit of r_addr1 / r_addr2 (combinational)
- w_en  in  1  write enable
- w_addr  in  AW  write address
- w_data  in  XLEN  write data
- rsv_en  in  1  reserve request: mark rsv_addr as having a pending writer
- rsv_addr  in  AW  register to reserve

## Operation
- FSM states:
  - CLEAR: clear counter `cnt` writes 0 to `rfile[cnt]` each cycle and increments. When `cnt == NREGS-1` is written, go to RUN.
  - RUN: normal operation; ready=1 only here.
- rst=1 on an edge forces CLEAR, sets cnt=0 and clears all busy bits. This applies in any state, so a mid-run reset restarts the full clear.
- In CLEAR:
  - w_en and rsv_en are ignored.
  - r_rs1, r_rs2 = 0.
  - rs1_busy, rs2_busy = 0.
- Write (RUN): w_en=1 stores w_data to rfile[w_addr] on the edge and clears busy[w_addr]. If ZERO_REG=1 and w_addr=0, the write does nothing.
- Reserve (RUN): rsv_en=1 sets busy[rsv_addr] on the edge. If ZERO_REG=1 and rsv_addr=0, it does nothing.
- Simultaneous write and reserve to the same address: the reservation wins. The data is written and busy ends at 1, because a new producer was issued.
- Read (RUN), per port:
  - If ZERO_REG=1 and addr=0: data 0, busy 0.
  - Else if w_en and w_addr == addr: data = w_data (forwarded) and busy = 0.
  - Else data = rfile[addr] and busy = busy[addr].
- Forwarding does not look at rsv_en in the same cycle. A same-cycle reservation only affects the following cycles.
- Reserving an already-busy register keeps it busy; no counting. Writing a non-busy register is legal.

## Timing
- Reset values:
  - ready=0.
  - busy[*]=0.
  - r_rs1=r_rs2=0 and rs1_busy=rs2_busy=0, because the outputs are gated in CLEAR.
- Clear latency:
  - After the last edge with rst=1, exactly NREGS edges are needed.
  - ready rises right after the NREGS-th edge; with NREGS=32 that is the 32nd edge.
  - If ZERO_REG=1, entry 0 is still cleared; this is harmless.
- Read latency is 0 cycles (combinational from address, w_* and state). Write and reserve latency is 1 edge.
- Writeback-to-decode in the same cycle sees the new value with no stall, through forwarding.

## Test plan
- Reset, then hold rst=0 with NREGS=32 → ready=0 for 31 edges and goes to 1 after the 32nd edge. Reading every address then returns 0 with busy=0.
- RUN: write x5=0xDEADBEEF, then read r_addr1=5 on the next cycle → 0xDEADBEEF. Write x0=0x1234 → r_addr2=0 reads 0.
- Forwarding: w_en=1, w_addr=7, w_data=0xA5A5A5A5 with r_addr1=r_addr2=7 in the same cycle → both ports show 0xA5A5A5A5 before the edge, with busy=0.
- Scoreboard: reserve x3, then read x3 → rs1_busy=1. Write x3=0x55 → busy=0 that same cycle (forwarded) and after the edge. Write and reserve x3 in the same cycle → busy=1 next cycle and data=the written value.
- Mid-run reset: write x9=0x77, assert rst for 1 cycle → ready=0, all busy=0, and 32 edges later x9 reads 0. w_en pulses during CLEAR have no effect.
- Width/depth: XLEN=64, NREGS=8, ZERO_REG=0 → clear takes 8 edges. Writing x0=0xFFFF_FFFF_FFFF_FFFF reads back the same value, and reserving x0 sets busy.
